reg_scoreboard_ctrl: RTL and testbench
======================================

Name: reg_scoreboard_ctrl

Overview:
- Issue controller for the decode stage; replaces the per-register valid-bit scheme with a scoreboard of pending writers.
- Tracks in-flight writes to the 16 scalar registers (R0-R15) using per-register counters.
- Decides each cycle whether the decoded instruction may issue, stalls it on RAW or counter saturation, and sequences branch-hold and pipeline-drain phases toward fetch.
- Sits between fetch/decode and writeback; the decode stage consumes O_IssueGrant and forwards the stall signals to fetch.

Parameters:
- NUM_REGS, 16, number of tracked scalar registers (register index width is fixed at 4).
- CNT_WIDTH, 2, width of each pending-writer counter; maximum in-flight writers per register = 2^CNT_WIDTH-1.

Ports:
- I_CLOCK  in  1  single clock, all state on posedge.
- I_RESET  in  1  synchronous reset, active-high.
- I_LOCK  in  1  pipeline enable; 0 freezes all state.
- I_IssueValid  in  1  decoded instruction present and not a fetch-stall bubble.
- I_Src1Use / I_Src2Use / I_Src3Use  in  1 each  source operand is read (Src3 = STW data register).
- I_Src1Idx / I_Src2Idx / I_Src3Idx  in  4 each  source register indices.
- I_DestUse  in  1  instruction writes a register.
- I_DestIdx  in  4  destination register index.
- I_IsBranch  in  1  instruction is BR*/JMP/JSR/JSRR.
- I_BranchResolved  in  1  one-cycle pulse from execute when the branch target is known.
- I_DrainReq  in  1  request to empty all pending writes (level).
- I_WriteBackEnable  in  1  writeback valid this cycle.
- I_WriteBackRegIdx  in  4  writeback register index.
- O_IssueGrant  out  1  instruction issues this cycle (combinational).
- O_DepStallSignal  out  1  instruction present but held (combinational).
- O_BranchStallSignal  out  1  fetch must hold (combinational).
- O_PendingMask  out  16  bit i = 1 when counter[i] != 0 (registered state).
- O_State  out  2  FSM state: 0=IDLE, 1=BR_WAIT, 2=DRAIN.
- O_WbError  out  1  sticky; set on writeback to a register whose counter is 0.

Behaviour:
- Reset (posedge with I_RESET=1, dominates everything, including mid-branch and mid-drain): all counters 0, State=IDLE, O_WbError=0. Combinational outputs therefore read 0 unless I_IssueValid drives them.
- I_LOCK=0: no state changes; O_IssueGrant, O_DepStallSignal and O_BranchStallSignal are 0.
- Effective pending for register r: cnt[r] minus 1 when I_WriteBackEnable=1 and I_WriteBackRegIdx=r (same-cycle writeback bypass). A source is blocked when it is used and its effective pending count is nonzero.
- Saturation block: I_DestUse=1 and effective cnt[I_DestIdx] equals 2^CNT_WIDTH-1.
- Hazard: I_IssueValid & I_LOCK & (any source blocked | saturation block | State != IDLE).
- O_IssueGrant = I_IssueValid & I_LOCK & !hazard. O_DepStallSignal = I_IssueValid & I_LOCK & hazard.
- Counter update, posedge with I_LOCK=1:
  - cnt[d] increments when O_IssueGrant=1 and I_DestUse=1.
  - cnt[w] decrements when writeback hits w and cnt[w] != 0.
  - Grant and writeback to the same register in one cycle leave the counter unchanged.
  - Writeback to a register with count 0 leaves the counter at 0 and sets O_WbError.
  - Counters never wrap.
- FSM, posedge with I_LOCK=1:
  - IDLE -> BR_WAIT when O_IssueGrant & I_IsBranch.
  - Otherwise IDLE -> DRAIN when I_DrainReq=1. A granted branch takes priority; the drain request stays pending (level) and is taken after the branch resolves.
  - BR_WAIT -> IDLE on I_BranchResolved. I_DrainReq is ignored while in BR_WAIT.
  - DRAIN -> IDLE when the next-state counters are all zero and I_DrainReq=0. DRAIN is held while I_DrainReq=1, even if the counters are empty.
  - I_BranchResolved is ignored in IDLE and DRAIN.
- O_BranchStallSignal = (State==BR_WAIT) | (O_IssueGrant & I_IsBranch), so fetch holds in the branch's own issue cycle. In the resolve cycle it is still 1; it deasserts on the following cycle.
- Issue latency is 0 cycles (same-cycle grant). Writeback-to-dependent-issue latency is 0 cycles via the bypass.

Test Plan:
- Reset, then ADD R1<-R2,R3 (dest 1, srcs 2,3) with I_IssueValid=1 -> Grant=1 and Stall=0; next cycle O_PendingMask=16'h0002.
- Then ADD R4<-R1,R2 -> Stall=1 and Grant=0 every cycle until I_WriteBackEnable=1 with idx=1. In that writeback cycle -> Grant=1; next cycle O_PendingMask=16'h0010.
- Issue dest=R5 three times (no writeback), then a fourth -> fourth has Stall=1 (cnt=3, saturated). Writeback R5 in the same cycle -> Grant=1 and cnt stays 3.
- Grant BRZ (I_IsBranch=1) -> BranchStall=1 the same cycle; State=1 next. Non-branch issues stall. Pulse I_BranchResolved -> State=0 the cycle after; BranchStall=0.
- R6 pending; assert I_DrainReq -> State=2 and all issues stall. Writeback R6, drop I_DrainReq -> State=0.
- Writeback R7 with mask 0 -> O_WbError=1 and stays 1. Assert I_RESET mid-BR_WAIT -> State=0, mask=0, WbError=0 next posedge.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback handshake bundle for the register scoreboard issue controller.
// The master drives decode and writeback information; the slave returns issue and stall decisions.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 16
);
  logic                lock;
  logic                issue_valid;
  logic                src1_use;
  logic                src2_use;
  logic                src3_use;
  logic [3:0]          src1_idx;
  logic [3:0]          src2_idx;
  logic [3:0]          src3_idx;
  logic                dest_use;
  logic [3:0]          dest_idx;
  logic                is_branch;
  logic                branch_resolved;
  logic                drain_req;
  logic                wb_enable;
  logic [3:0]          wb_reg_idx;
  logic                issue_grant;
  logic                dep_stall;
  logic                branch_stall;
  logic [NUM_REGS-1:0] pending_mask;
  logic [1:0]          state;
  logic                wb_error;

  modport master (
    output lock, issue_valid, src1_use, src2_use, src3_use,
    output src1_idx, src2_idx, src3_idx, dest_use, dest_idx,
    output is_branch, branch_resolved, drain_req, wb_enable, wb_reg_idx,
    input  issue_grant, dep_stall, branch_stall, pending_mask, state, wb_error
  );

  modport slave (
    input  lock, issue_valid, src1_use, src2_use, src3_use,
    input  src1_idx, src2_idx, src3_idx, dest_use, dest_idx,
    input  is_branch, branch_resolved, drain_req, wb_enable, wb_reg_idx,
    output issue_grant, dep_stall, branch_stall, pending_mask, state, wb_error
  );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// Decode-stage issue controller: per-register pending-writer counters gate issue on RAW and
// saturation, and a small FSM holds fetch across branches and pipeline drains.
module reg_scoreboard_ctrl #(
  parameter int NUM_REGS  = 16,
  parameter int CNT_WIDTH = 2
) (
  input  logic             I_CLOCK,
  input  logic             I_RESET,
  reg_scoreboard_if.slave  sb
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BR_WAIT = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_r;
  logic [CNT_WIDTH-1:0]  cnt_r      [NUM_REGS];
  logic [CNT_WIDTH-1:0]  eff_cnt_s  [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_nxt_s  [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_mask_r;
  logic [NUM_REGS-1:0]   mask_nxt_s;
  logic                  wb_error_r;
  logic                  present_s;
  logic                  blocked_s;
  logic                  sat_s;
  logic                  hazard_s;
  logic                  grant_s;
  logic                  wb_zero_hit_s;

  // Effective counts subtract a same-cycle writeback so a dependent can issue with zero bubbles.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (sb.wb_enable && (sb.wb_reg_idx == 4'(r)) && (cnt_r[r] != CNT_ZERO)) begin
        eff_cnt_s[r] = cnt_r[r] - CNT_ONE;
      end else begin
        eff_cnt_s[r] = cnt_r[r];
      end
    end
  end

  // Issue decision: RAW on any used source, writer-count saturation, or a non-idle phase.
  always_comb begin
    present_s = sb.issue_valid && sb.lock;
    blocked_s = (sb.src1_use && (eff_cnt_s[sb.src1_idx] != CNT_ZERO)) ||
                (sb.src2_use && (eff_cnt_s[sb.src2_idx] != CNT_ZERO)) ||
                (sb.src3_use && (eff_cnt_s[sb.src3_idx] != CNT_ZERO));
    sat_s     = sb.dest_use && (eff_cnt_s[sb.dest_idx] == CNT_MAX);
    hazard_s  = present_s && (blocked_s || sat_s || (state_r != IDLE));
    grant_s   = present_s && !hazard_s;
  end

  // Next counter values; a grant and a writeback on the same register cancel out.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc_v;
      logic dec_v;
      inc_v = grant_s && sb.dest_use && (sb.dest_idx == 4'(r));
      dec_v = sb.wb_enable && (sb.wb_reg_idx == 4'(r)) && (cnt_r[r] != CNT_ZERO);
      if (inc_v && !dec_v) begin
        cnt_nxt_s[r] = cnt_r[r] + CNT_ONE;
      end else if (dec_v && !inc_v) begin
        cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
      end else begin
        cnt_nxt_s[r] = cnt_r[r];
      end
      mask_nxt_s[r] = (cnt_nxt_s[r] != CNT_ZERO);
    end
    wb_zero_hit_s = sb.wb_enable && (cnt_r[sb.wb_reg_idx] == CNT_ZERO);
  end

  // Counter, pending-mask and sticky writeback-error state.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
      pending_mask_r <= {NUM_REGS{1'b0}};
      wb_error_r     <= 1'b0;
    end else if (sb.lock) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
      pending_mask_r <= mask_nxt_s;
      wb_error_r     <= wb_error_r || wb_zero_hit_s;
    end else begin
      pending_mask_r <= pending_mask_r;
      wb_error_r     <= wb_error_r;
    end
  end

  // Phase FSM: a granted branch wins over a pending drain request; drain holds while requested.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state_r <= IDLE;
    end else if (sb.lock) begin
      case (state_r)
        IDLE: begin
          if (grant_s && sb.is_branch) begin
            state_r <= BR_WAIT;
          end else if (sb.drain_req) begin
            state_r <= DRAIN;
          end else begin
            state_r <= IDLE;
          end
        end
        BR_WAIT: begin
          if (sb.branch_resolved) begin
            state_r <= IDLE;
          end else begin
            state_r <= BR_WAIT;
          end
        end
        DRAIN: begin
          if ((mask_nxt_s == {NUM_REGS{1'b0}}) && !sb.drain_req) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: state_r <= IDLE;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign sb.issue_grant  = grant_s;
  assign sb.dep_stall    = hazard_s;
  assign sb.branch_stall = sb.lock && ((state_r == BR_WAIT) || (grant_s && sb.is_branch));
  assign sb.pending_mask = pending_mask_r;
  assign sb.state        = state_r;
  assign sb.wb_error     = wb_error_r;

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Table-driven bench for reg_scoreboard_ctrl: each row is one cycle; combinational outputs are
// checked before the edge, registered outputs are queued at drive time and checked after it.
module tb_reg_scoreboard_ctrl;

  localparam int N = -1;

  typedef struct {
    logic        rst;
    logic        lock;
    logic        iv;
    int          s1;
    int          s2;
    int          s3;
    int          d;
    logic        br;
    logic        res;
    logic        drn;
    int          wb;
    logic        e_grant;
    logic        e_dep;
    logic        e_bst;
    logic [15:0] e_mask;
    logic [1:0]  e_state;
    logic        e_err;
  } vec_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  vec_t vecs[$];
  vec_t exp_q[$];

  reg_scoreboard_if #(.NUM_REGS(16)) sb_if ();

  reg_scoreboard_ctrl #(.NUM_REGS(16), .CNT_WIDTH(2)) dut (
    .I_CLOCK (clk),
    .I_RESET (rst),
    .sb      (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, input int lk, input int iv, input int s1, input int s2,
                              input int s3, input int d, input int br, input int res, input int drn,
                              input int wb, input int eg, input int ed, input int eb,
                              input int emask, input int est, input int eerr);
    vec_t v;
    v.rst = 1'(r); v.lock = 1'(lk); v.iv = 1'(iv);
    v.s1 = s1; v.s2 = s2; v.s3 = s3; v.d = d;
    v.br = 1'(br); v.res = 1'(res); v.drn = 1'(drn); v.wb = wb;
    v.e_grant = 1'(eg); v.e_dep = 1'(ed); v.e_bst = 1'(eb);
    v.e_mask = 16'(emask); v.e_state = 2'(est); v.e_err = 1'(eerr);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst                   = v.rst;
    sb_if.lock            = v.lock;
    sb_if.issue_valid     = v.iv;
    sb_if.src1_use        = (v.s1 >= 0);
    sb_if.src1_idx        = (v.s1 >= 0) ? 4'(v.s1) : 4'd0;
    sb_if.src2_use        = (v.s2 >= 0);
    sb_if.src2_idx        = (v.s2 >= 0) ? 4'(v.s2) : 4'd0;
    sb_if.src3_use        = (v.s3 >= 0);
    sb_if.src3_idx        = (v.s3 >= 0) ? 4'(v.s3) : 4'd0;
    sb_if.dest_use        = (v.d >= 0);
    sb_if.dest_idx        = (v.d >= 0) ? 4'(v.d) : 4'd0;
    sb_if.is_branch       = v.br;
    sb_if.branch_resolved = v.res;
    sb_if.drain_req       = v.drn;
    sb_if.wb_enable       = (v.wb >= 0);
    sb_if.wb_reg_idx      = (v.wb >= 0) ? 4'(v.wb) : 4'd0;
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    //        rst lk iv s1 s2 s3 d  br res drn wb   grant dep bst mask      st err
    vecs.push_back(mk(1, 1, 0, N, N, N, N, 0, 0, 0, N,  0, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, N,  0, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 3, N, 1, 0, 0, 0, N,  1, 0, 0, 16'h0002, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 2, N, 4, 0, 0, 0, N,  0, 1, 0, 16'h0002, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 2, N, 4, 0, 0, 0, N,  0, 1, 0, 16'h0002, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 2, N, 4, 0, 0, 0, 1,  1, 0, 0, 16'h0010, 0, 0));
    vecs.push_back(mk(0, 1, 1, N, N, N, 5, 0, 0, 0, N,  1, 0, 0, 16'h0030, 0, 0));
    vecs.push_back(mk(0, 1, 1, N, N, N, 5, 0, 0, 0, N,  1, 0, 0, 16'h0030, 0, 0));
    vecs.push_back(mk(0, 1, 1, N, N, N, 5, 0, 0, 0, N,  1, 0, 0, 16'h0030, 0, 0));
    vecs.push_back(mk(0, 1, 1, N, N, N, 5, 0, 0, 0, N,  0, 1, 0, 16'h0030, 0, 0));
    vecs.push_back(mk(0, 1, 1, N, N, N, 5, 0, 0, 0, 5,  1, 0, 0, 16'h0030, 0, 0));
    vecs.push_back(mk(0, 1, 1, N, N, 4, N, 0, 0, 0, N,  0, 1, 0, 16'h0030, 0, 0));
    // branch hold, then a frozen cycle, then resolve
    vecs.push_back(mk(0, 1, 1, N, N, N, N, 1, 0, 0, N,  1, 0, 1, 16'h0030, 1, 0));
    vecs.push_back(mk(0, 1, 1, N, N, N, 8, 0, 0, 0, N,  0, 1, 1, 16'h0030, 1, 0));
    vecs.push_back(mk(0, 0, 1, N, N, N, 8, 0, 1, 0, 4,  0, 0, 0, 16'h0030, 1, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 1, 0, N,  0, 0, 1, 16'h0030, 0, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, N,  0, 0, 0, 16'h0030, 0, 0));
    // retire R4 and three R5 writers
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, 4,  0, 0, 0, 16'h0020, 0, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, 5,  0, 0, 0, 16'h0020, 0, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, 5,  0, 0, 0, 16'h0020, 0, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, 5,  0, 0, 0, 16'h0000, 0, 0));
    // drain with R6 pending; held while requested even once empty
    vecs.push_back(mk(0, 1, 1, N, N, N, 6, 0, 0, 0, N,  1, 0, 0, 16'h0040, 0, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 1, N,  0, 0, 0, 16'h0040, 2, 0));
    vecs.push_back(mk(0, 1, 1, N, N, N, 9, 0, 0, 1, N,  0, 1, 0, 16'h0040, 2, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 1, 6,  0, 0, 0, 16'h0000, 2, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 1, 1, N,  0, 0, 0, 16'h0000, 2, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, N,  0, 0, 0, 16'h0000, 0, 0));
    // branch beats drain; drain taken after resolve
    vecs.push_back(mk(0, 1, 1, N, N, N, N, 1, 0, 1, N,  1, 0, 1, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 1, 1, N,  0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 1, N,  0, 0, 0, 16'h0000, 2, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, N,  0, 0, 0, 16'h0000, 0, 0));
    // writeback error is sticky; reset clears it mid-branch
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, 7,  0, 0, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, N,  0, 0, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 1, 1, N, N, N, 7, 1, 0, 0, N,  1, 0, 1, 16'h0080, 1, 1));
    vecs.push_back(mk(1, 1, 0, N, N, N, N, 0, 0, 0, N,  0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, N, N, N, N, 0, 0, 0, N,  0, 0, 0, 16'h0000, 0, 0));

    // unchecked reset cycle so the first row sees defined state
    drive(mk(1, 1, 0, N, N, N, N, 0, 0, 0, N, 0, 0, 0, 0, 0, 0));
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      #2;
      chk("grant",        i, 32'(sb_if.issue_grant),  32'(vecs[i].e_grant));
      chk("dep_stall",    i, 32'(sb_if.dep_stall),    32'(vecs[i].e_dep));
      chk("branch_stall", i, 32'(sb_if.branch_stall), 32'(vecs[i].e_bst));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("pending_mask", i, 32'(sb_if.pending_mask), 32'(e.e_mask));
      chk("state",        i, 32'(sb_if.state),        32'(e.e_state));
      chk("wb_error",     i, 32'(sb_if.wb_error),     32'(e.e_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
